// File: rtl/pc_pkg.sv
// Shared defaults and state encoding for the fetch program-counter unit.
package pc_pkg;

   localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_4180;
   localparam int unsigned PC_STEP_DEF      = 4;

   typedef enum logic {
      PC_RUN  = 1'b0,
      PC_HOLD = 1'b1
   } pc_state_t;

endpackage : pc_pkg

// File: rtl/pc_addr_check.sv
// Combinational fetch-address checker: flags misaligned or out-of-window PCs.
module pc_addr_check #(
   parameter int unsigned      WIDTH   = 32,
   parameter logic [WIDTH-1:0] IMEM_LO = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] IMEM_HI = WIDTH'(32'h0000_6FFC)
) (
   input  logic [WIDTH-1:0] i_pc,
   output logic             o_adel
);

   logic w_misaligned;
   logic w_below;
   logic w_above;

   always_comb begin
      w_misaligned = (i_pc[1:0] != 2'b00);
      w_below      = (i_pc < IMEM_LO);
      w_above      = (i_pc > IMEM_HI);
      o_adel       = w_misaligned | w_below | w_above;
   end

endmodule : pc_addr_check

// File: rtl/pc_unit.sv
// Fetch program counter with stall-buffered redirects.
// Optional address checker enabled by defining PC_ADDR_CHECK_EN.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DEF),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC_DEF),
   parameter int unsigned      STEP      = PC_STEP_DEF,
   parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(32'h0000_6FFC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   input  logic             stall,
   input  logic             redir_valid,
   input  logic [WIDTH-1:0] redir_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic             redir_pending,
   output logic             adel
);

   pc_state_t        r_state;
   pc_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] r_pend;
   logic [WIDTH-1:0] w_pend_nxt;
   logic [WIDTH-1:0] w_pc_plus;
   logic             w_adel;

   assign w_pc_plus = r_pc + WIDTH'(STEP);

   // Priority chain: exception, eret, stall, live redirect, buffered redirect, step.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = w_pc_plus;
      w_pend_nxt  = r_pend;
      if (req) begin
         w_pc_nxt    = EXC_VEC;
         w_state_nxt = PC_RUN;
      end else if (eret) begin
         w_pc_nxt    = epc;
         w_state_nxt = PC_RUN;
      end else if (stall) begin
         w_pc_nxt = r_pc;
         if (redir_valid) begin
            w_pend_nxt  = redir_target;
            w_state_nxt = PC_HOLD;
         end
      end else if (redir_valid) begin
         w_pc_nxt    = redir_target;
         w_state_nxt = PC_RUN;
      end else if (r_state == PC_HOLD) begin
         w_pc_nxt    = r_pend;
         w_state_nxt = PC_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= PC_RUN;
         r_pc    <= RESET_VEC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // The buffered target is meaningless outside HOLD, so it carries no reset.
   always_ff @(posedge clk) begin
      r_pend <= w_pend_nxt;
   end

`ifdef PC_ADDR_CHECK_EN
   pc_addr_check #(
      .WIDTH   (WIDTH),
      .IMEM_LO (IMEM_LO),
      .IMEM_HI (IMEM_HI)
   ) u_addr_check (
      .i_pc   (r_pc),
      .o_adel (w_adel)
   );
`else
   assign w_adel = 1'b0;
`endif

   assign pc            = r_pc;
   assign pc_plus       = w_pc_plus;
   assign redir_pending = (r_state == PC_HOLD);
   assign adel          = w_adel;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed plan sequences then random traffic.
module tb_pc_unit;

   localparam logic [31:0] RV   = 32'h0000_3000;
   localparam logic [31:0] EV   = 32'h0000_4180;
   localparam logic [31:0] LO   = 32'h0000_3000;
   localparam logic [31:0] HI   = 32'h0000_6FFC;

   typedef struct {
      logic [31:0] pc;
      logic        pend;
      logic        adel;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] epc = '0;
   logic        stall = 1'b0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_target = '0;
   logic [31:0] pc;
   logic [31:0] pc_plus;
   logic        redir_pending;
   logic        adel;

   int   total = 0;
   int   bad = 0;
   exp_t q[$];

   // Reference state: what the front end "remembers" at a high level.
   logic [31:0] m_pc = RV;
   bit          m_has_buf = 0;
   logic [31:0] m_buf = '0;

   pc_unit #(.WIDTH(32), .RESET_VEC(RV), .EXC_VEC(EV), .STEP(4),
             .IMEM_LO(LO), .IMEM_HI(HI)) dut (
      .clk(clk), .reset(reset), .req(req), .eret(eret), .epc(epc),
      .stall(stall), .redir_valid(redir_valid), .redir_target(redir_target),
      .pc(pc), .pc_plus(pc_plus), .redir_pending(redir_pending), .adel(adel));

   always #5 clk = ~clk;

   function automatic logic exp_adel(input logic [31:0] a);
`ifdef PC_ADDR_CHECK_EN
      return (a % 4 != 0) || (a < LO) || (a > HI);
`else
      return 1'b0 & a[0];
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst_n, input bit rq, input bit er, input logic [31:0] ep,
                       input bit st, input bit rv, input logic [31:0] rt);
      exp_t e;
      @(negedge clk);
      reset = rst_n; req = rq; eret = er; epc = ep;
      stall = st; redir_valid = rv; redir_target = rt;
      if (!rst_n) begin
         m_pc = RV; m_has_buf = 0;
      end else if (rq) begin
         m_pc = EV; m_has_buf = 0;
      end else if (er) begin
         m_pc = ep; m_has_buf = 0;
      end else if (st) begin
         if (rv) begin m_buf = rt; m_has_buf = 1; end
      end else if (rv) begin
         m_pc = rt; m_has_buf = 0;
      end else if (m_has_buf) begin
         m_pc = m_buf; m_has_buf = 0;
      end else begin
         m_pc = m_pc + 32'd4;
      end
      e.pc = m_pc; e.pend = m_has_buf; e.adel = exp_adel(m_pc);
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, 0, '0);
   endtask

   // Monitor: every cycle the DUT presents a new pc; compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pc", pc, e.pc);
            check("pc_plus", pc_plus, e.pc + 32'd4);
            check("redir_pending", {31'd0, redir_pending}, {31'd0, e.pend});
            check("adel", {31'd0, adel}, {31'd0, e.adel});
         end
      end
   end

   initial begin
      logic [31:0] t;
      // Reset and run
      step(0, 0, 0, '0, 0, 0, '0);
      step(0, 0, 0, '0, 0, 0, '0);
      idle(2);
      // Stalled redirect
      step(1, 0, 0, '0, 1, 1, 32'h3100);
      step(1, 0, 0, '0, 1, 0, '0);
      step(1, 0, 0, '0, 1, 0, '0);
      idle(2);
      // Overwrite during stall
      step(1, 0, 0, '0, 1, 1, 32'h3100);
      step(1, 0, 0, '0, 1, 1, 32'h3200);
      idle(2);
      // Live redirect overrides buffered one
      step(1, 0, 0, '0, 1, 1, 32'h3100);
      step(1, 0, 0, '0, 0, 1, 32'h3300);
      idle(1);
      // Exception priority with pending redirect
      step(1, 0, 0, '0, 1, 1, 32'h3100);
      step(1, 1, 1, 32'h3010, 1, 1, 32'h3500);
      step(1, 0, 1, 32'h3010, 0, 0, '0);
      idle(1);
      // Reset mid-HOLD
      step(1, 0, 0, '0, 1, 1, 32'h3400);
      step(0, 0, 0, '0, 0, 0, '0);
      idle(2);
      // Address check sequence
      step(1, 0, 0, '0, 0, 1, 32'h3002);
      step(1, 0, 0, '0, 0, 1, 32'h7000);
      step(1, 0, 1, 32'h3004, 0, 0, '0);
      step(1, 0, 0, '0, 0, 1, 32'h6FFC);
      step(1, 0, 0, '0, 0, 1, 32'h2FFC);
      // Wrap at the top of the address space
      step(1, 0, 0, '0, 0, 1, 32'hFFFF_FFFC);
      idle(2);
      // Random traffic
      for (int i = 0; i < 600; i++) begin
         t = 32'h2FF0 + ($urandom_range(0, 16400) & 32'hFFFF_FFFC);
         if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 19) == 0), t ^ 32'h0000_0100,
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), t);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pc_unit
